// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM bank arbiter.
//   NUM_REQ      number of requesters sharing the buffer
//   REQ_RX/TX/WB requester indices: MAC RX writer, MAC TX reader, Wishbone slave
//   arb_state_e  access sequencer states
//   bank_csb_n   bank number -> active-low one-cold chip-select vector
package sram_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int MAX_BANKS = 16;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_RX = 2'd0;
    localparam req_idx_t REQ_TX = 2'd1;
    localparam req_idx_t REQ_WB = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Callers keep the low NUM_BANKS bits of the result.
    function automatic logic [MAX_BANKS-1:0] bank_csb_n(input int unsigned bank);
        bank_csb_n = ~(MAX_BANKS'(1) << bank);
    endfunction

endpackage

// File: rtl/sram_rr_picker.sv
// Combinational three-way round-robin picker.
//   eligible_i    requesters that may be granted this cycle
//   last_grant_i  index of the most recently served requester
//   grant_o       one-hot grant, the first eligible requester after last_grant_i
//   valid_o       high when grant_o has a bit set
module sram_rr_picker
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible_i,
    input  req_idx_t           last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);

    always_comb begin
        req_idx_t idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        // Scan starting one past the last winner and wrapping; the last
        // winner is visited last so it only wins when nobody else asks.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = req_idx_t'((int'(last_grant_i) + k) % NUM_REQ);
            if (!valid_o && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares the banked single-port SRAM packet buffer between the MAC RX writer,
// the MAC TX reader and the Wishbone slave. One access is in flight at a time:
// IDLE picks a requester and drives the chip select for one cycle, CMD lets the
// macro sample, RESP captures read data and pulses the requester's ack.
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   rx_req_i/addr/wdata, rx_ack_o RX full-word writes
//   tx_req_i/addr, tx_ack_o/rdata TX reads
//   wb_req_i/we/addr/sel/wdata,
//   wb_ack_o/rdata                Wishbone byte-masked writes and reads
//   sram_csb_o                    per-bank chip select, active-low
//   sram_web_o/wmask/addr/din     shared macro command bus (all registered)
//   sram_dout_i                   concatenated macro read data, bank n at [DW*n +: DW]
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 10,
    parameter int DW        = 32,
    parameter int AW        = 12
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    rx_req_i,
    input  logic [AW-1:0]           rx_addr_i,
    input  logic [DW-1:0]           rx_wdata_i,
    output logic                    rx_ack_o,

    input  logic                    tx_req_i,
    input  logic [AW-1:0]           tx_addr_i,
    output logic                    tx_ack_o,
    output logic [DW-1:0]           tx_rdata_o,

    input  logic                    wb_req_i,
    input  logic                    wb_we_i,
    input  logic [AW-1:0]           wb_addr_i,
    input  logic [DW/8-1:0]         wb_sel_i,
    input  logic [DW-1:0]           wb_wdata_i,
    output logic                    wb_ack_o,
    output logic [DW-1:0]           wb_rdata_o,

    output logic [NUM_BANKS-1:0]    sram_csb_o,
    output logic                    sram_web_o,
    output logic [DW/8-1:0]         sram_wmask_o,
    output logic [BANK_AW-1:0]      sram_addr_o,
    output logic [DW-1:0]           sram_din_o,
    input  logic [NUM_BANKS*DW-1:0] sram_dout_i
);

    localparam int MW    = DW / 8;
    localparam int BNK_W = AW - BANK_AW;

    arb_state_e           state_q, state_d;
    req_idx_t             grant_q, grant_d;
    req_idx_t             last_q, last_d;
    logic [BNK_W-1:0]     bank_q, bank_d;
    logic                 rd_q, rd_d;

    logic [NUM_BANKS-1:0] csb_q, csb_d;
    logic                 web_q, web_d;
    logic [MW-1:0]        wmask_q, wmask_d;
    logic [BANK_AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]        din_q, din_d;

    logic                 rx_ack_q, rx_ack_d;
    logic                 tx_ack_q, tx_ack_d;
    logic                 wb_ack_q, wb_ack_d;
    logic [DW-1:0]        tx_rdata_q, tx_rdata_d;
    logic [DW-1:0]        wb_rdata_q, wb_rdata_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   pick_oh;
    logic                 pick_vld;
    req_idx_t             pick_idx;

    logic                 req_we;
    logic [AW-1:0]        req_addr;
    logic [DW-1:0]        req_din;
    logic [MW-1:0]        req_mask;
    logic [BNK_W-1:0]     req_bank;
    logic [MAX_BANKS-1:0] req_csb_full;
    logic [DW-1:0]        bank_rdata;

    // A requester whose ack is high this cycle still has req up for the
    // access just finished; masking it keeps that stale level from being
    // taken as a second access.
    assign eligible = {wb_req_i & ~wb_ack_q,
                       tx_req_i & ~tx_ack_q,
                       rx_req_i & ~rx_ack_q};

    sram_rr_picker u_picker (
        .eligible_i   (eligible),
        .last_grant_i (last_q),
        .grant_o      (pick_oh),
        .valid_o      (pick_vld)
    );

    always_comb begin
        pick_idx = REQ_RX;
        if (pick_oh[REQ_TX]) begin
            pick_idx = REQ_TX;
        end else if (pick_oh[REQ_WB]) begin
            pick_idx = REQ_WB;
        end
    end

    // Command fields of the requester being picked.
    always_comb begin
        req_we   = 1'b0;
        req_addr = '0;
        req_din  = '0;
        req_mask = '0;
        unique case (pick_idx)
            REQ_RX: begin
                req_we   = 1'b1;
                req_addr = rx_addr_i;
                req_din  = rx_wdata_i;
                req_mask = '1;
            end
            REQ_TX: begin
                req_addr = tx_addr_i;
            end
            REQ_WB: begin
                req_we   = wb_we_i;
                req_addr = wb_addr_i;
                req_din  = wb_wdata_i;
                req_mask = wb_sel_i;
            end
            default: ;
        endcase
        req_bank     = req_addr[AW-1:BANK_AW];
        req_csb_full = bank_csb_n(32'(req_bank));
    end

    assign bank_rdata = sram_dout_i[DW*int'(bank_q) +: DW];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        bank_d     = bank_q;
        rd_d       = rd_q;
        // Chip selects and write enable fall back to inactive every cycle,
        // so a select is only ever low for the single cycle after a grant.
        csb_d      = '1;
        web_d      = 1'b1;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rx_ack_d   = 1'b0;
        tx_ack_d   = 1'b0;
        wb_ack_d   = 1'b0;
        tx_rdata_d = tx_rdata_q;
        wb_rdata_d = wb_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    bank_d  = req_bank;
                    rd_d    = ~req_we;
                    csb_d   = req_csb_full[NUM_BANKS-1:0];
                    web_d   = ~req_we;
                    wmask_d = req_mask;
                    addr_d  = req_addr[BANK_AW-1:0];
                    din_d   = req_din;
                    state_d = CMD;
                end
            end
            CMD: begin
                state_d = RESP;
            end
            RESP: begin
                unique case (grant_q)
                    REQ_RX: rx_ack_d = 1'b1;
                    REQ_TX: begin
                        tx_ack_d   = 1'b1;
                        tx_rdata_d = bank_rdata;
                    end
                    REQ_WB: begin
                        wb_ack_d = 1'b1;
                        // Macro output is not meaningful after a write, so
                        // a Wishbone write leaves the last read data in place.
                        if (rd_q) begin
                            wb_rdata_d = bank_rdata;
                        end
                    end
                    default: ;
                endcase
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            grant_q    <= REQ_RX;
            last_q     <= REQ_WB;
            bank_q     <= '0;
            rd_q       <= 1'b0;
            csb_q      <= '1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rx_ack_q   <= 1'b0;
            tx_ack_q   <= 1'b0;
            wb_ack_q   <= 1'b0;
            tx_rdata_q <= '0;
            wb_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            bank_q     <= bank_d;
            rd_q       <= rd_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rx_ack_q   <= rx_ack_d;
            tx_ack_q   <= tx_ack_d;
            wb_ack_q   <= wb_ack_d;
            tx_rdata_q <= tx_rdata_d;
            wb_rdata_q <= wb_rdata_d;
        end
    end

    assign sram_csb_o   = csb_q;
    assign sram_web_o   = web_q;
    assign sram_wmask_o = wmask_q;
    assign sram_addr_o  = addr_q;
    assign sram_din_o   = din_q;
    assign rx_ack_o     = rx_ack_q;
    assign tx_ack_o     = tx_ack_q;
    assign tx_rdata_o   = tx_rdata_q;
    assign wb_ack_o     = wb_ack_q;
    assign wb_rdata_o   = wb_rdata_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: behavioural SRAM macros, a transaction-level
// expectation model with a word-array scoreboard, and directed/random traffic.
module tb_sram_bank_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         rx_req = 1'b0;
    logic [11:0]  rx_addr = '0;
    logic [31:0]  rx_wdata = '0;
    logic         rx_ack_o;
    logic         tx_req = 1'b0;
    logic [11:0]  tx_addr = '0;
    logic         tx_ack_o;
    logic [31:0]  tx_rdata_o;
    logic         wb_req = 1'b0;
    logic         wb_we = 1'b0;
    logic [11:0]  wb_addr = '0;
    logic [3:0]   wb_sel = '0;
    logic [31:0]  wb_wdata = '0;
    logic         wb_ack_o;
    logic [31:0]  wb_rdata_o;
    logic [3:0]   sram_csb;
    logic         sram_web;
    logic [3:0]   sram_wmask;
    logic [9:0]   sram_addr;
    logic [31:0]  sram_din;
    logic [127:0] sram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_bank_arbiter dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .rx_req_i     (rx_req),
        .rx_addr_i    (rx_addr),
        .rx_wdata_i   (rx_wdata),
        .rx_ack_o     (rx_ack_o),
        .tx_req_i     (tx_req),
        .tx_addr_i    (tx_addr),
        .tx_ack_o     (tx_ack_o),
        .tx_rdata_o   (tx_rdata_o),
        .wb_req_i     (wb_req),
        .wb_we_i      (wb_we),
        .wb_addr_i    (wb_addr),
        .wb_sel_i     (wb_sel),
        .wb_wdata_i   (wb_wdata),
        .wb_ack_o     (wb_ack_o),
        .wb_rdata_o   (wb_rdata_o),
        .sram_csb_o   (sram_csb),
        .sram_web_o   (sram_web),
        .sram_wmask_o (sram_wmask),
        .sram_addr_o  (sram_addr),
        .sram_din_o   (sram_din),
        .sram_dout_i  (sram_dout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A0000 | 32'(i);
    endfunction

    // ---------------- SRAM macros (environment) ----------------
    logic [31:0] macro_mem [4096];
    logic [31:0] mdout [4];
    bit          minit = 1'b0;

    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 4096; i++) macro_mem[i] <= init_word(i);
            for (int b = 0; b < 4; b++) mdout[b] <= '0;
            minit <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_csb[b[1:0]]) begin
                    if (!sram_web) begin
                        for (int j = 0; j < 4; j++)
                            if (sram_wmask[j[1:0]])
                                macro_mem[{b[1:0], sram_addr}][8*j +: 8] <= sram_din[8*j +: 8];
                    end else begin
                        mdout[b] <= macro_mem[{b[1:0], sram_addr}];
                    end
                end
            end
        end
    end
    assign sram_dout = {mdout[3], mdout[2], mdout[1], mdout[0]};

    // ---------------- expectation model ----------------
    // Transaction view: an access starts at the edge it is granted (select
    // visible for one cycle), the word array changes one edge later, and the
    // ack/data appear the edge after that. Round-robin over {RX,TX,WB}.
    logic [31:0] sb_mem [4096];
    bit          sinit = 1'b0;
    int          m_age = -1;
    logic [1:0]  m_last = 2'd2;
    logic [1:0]  m_cur = 2'd0;
    logic [11:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_mask = '0;
    logic [31:0] m_din = '0;
    logic [3:0]  e_csb = 4'hF;
    logic        e_web = 1'b1;
    logic [9:0]  e_addr = '0;
    logic [3:0]  e_mask = '0;
    logic [31:0] e_din = '0;
    logic [2:0]  e_ack = '0;
    logic [31:0] e_tx_rd = '0;
    logic [31:0] e_wb_rd = '0;
    bit          e_wb_isrd = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [2:0] elig;
        logic [1:0] r;
        bit         found;
        if (rst) begin
            if (!sinit) begin
                for (int i = 0; i < 4096; i++) sb_mem[i] = init_word(i);
                sinit = 1'b1;
            end
            m_age   = -1;
            m_last  = 2'd2;
            e_csb   = 4'hF;
            e_web   = 1'b1;
            e_ack   = '0;
            e_tx_rd = '0;
            e_wb_rd = '0;
        end else begin
            elig  = {wb_req, tx_req, rx_req} & ~e_ack;
            e_ack = '0;
            e_csb = 4'hF;
            e_web = 1'b1;
            if (m_age == 0) begin
                if (m_we)
                    for (int j = 0; j < 4; j++)
                        if (m_mask[j[1:0]]) sb_mem[m_addr][8*j +: 8] = m_din[8*j +: 8];
                m_age = 1;
            end else if (m_age == 1) begin
                e_ack[m_cur] = 1'b1;
                if (m_cur == 2'd1) e_tx_rd = sb_mem[m_addr];
                if (m_cur == 2'd2) begin
                    e_wb_isrd = !m_we;
                    if (!m_we) e_wb_rd = sb_mem[m_addr];
                end
                m_last = m_cur;
                m_age  = -1;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    r = 2'((int'(m_last) + k) % 3);
                    if (!found && elig[r]) begin
                        m_cur = r;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    case (m_cur)
                        2'd0: begin m_addr = rx_addr; m_we = 1'b1; m_mask = 4'hF; m_din = rx_wdata; end
                        2'd1: begin m_addr = tx_addr; m_we = 1'b0; m_mask = 4'h0; m_din = '0; end
                        default: begin m_addr = wb_addr; m_we = wb_we; m_mask = wb_sel; m_din = wb_wdata; end
                    endcase
                    e_csb  = ~(4'b0001 << m_addr[11:10]);
                    e_web  = ~m_we;
                    e_addr = m_addr[9:0];
                    e_mask = m_mask;
                    e_din  = m_din;
                    m_age  = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("csb", 64'(sram_csb), 64'(e_csb));
            chk("web", 64'(sram_web), 64'(e_web));
            chk("acks", 64'({wb_ack_o, tx_ack_o, rx_ack_o}), 64'(e_ack));
            chk("csb_onehot", 64'($countones(~sram_csb) <= 1), 64'(1));
            if (e_csb != 4'hF) begin
                chk("addr", 64'(sram_addr), 64'(e_addr));
                chk("wmask", 64'(sram_wmask), 64'(e_mask));
                if (!e_web) chk("din", 64'(sram_din), 64'(e_din));
            end
            if (e_ack[1]) chk("tx_rdata", 64'(tx_rdata_o), 64'(e_tx_rd));
            if (e_ack[2] && e_wb_isrd) chk("wb_rdata", 64'(wb_rdata_o), 64'(e_wb_rd));
        end
    end

    // ---------------- driver helpers ----------------
    bit   rx_hold = 1'b0, tx_hold = 1'b0, wb_hold = 1'b0;
    int   cyc = 0;
    int   order [$];
    int   tx_ack_cyc [$];
    logic [3:0] csb_log [$];
    logic [31:0] last_tx_rd = '0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (sram_csb != 4'hF) csb_log.push_back(sram_csb);
        if (rx_ack_o) begin
            order.push_back(0);
            if (!rx_hold) rx_req = 1'b0;
        end
        if (tx_ack_o) begin
            order.push_back(1);
            tx_ack_cyc.push_back(cyc);
            last_tx_rd = tx_rdata_o;
            if (!tx_hold) tx_req = 1'b0;
        end
        if (wb_ack_o) begin
            order.push_back(2);
            if (!wb_hold) wb_req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_req = 1'b0; tx_req = 1'b0; wb_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [11:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd);
        int lat;
        wb_req = 1'b1; wb_we = we; wb_addr = a; wb_sel = s; wb_wdata = d;
        lat = 0;
        do begin step(); lat++; end while (!wb_ack_o && lat < 20);
        chk("wb_latency", 64'(lat), 64'(3));
        rd = wb_rdata_o;
        idle(1);
    endtask

    task automatic tx_xfer(input logic [11:0] a, output logic [31:0] rd);
        int lat;
        tx_req = 1'b1; tx_addr = a;
        lat = 0;
        do begin step(); lat++; end while (!tx_ack_o && lat < 20);
        chk("tx_latency", 64'(lat), 64'(3));
        rd = tx_rdata_o;
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Reset in the command cycle aborts the access.
        wb_req = 1'b1; wb_we = 1'b1; wb_addr = 12'h123; wb_sel = 4'hF; wb_wdata = 32'h11112222;
        step();
        chk("t1_csb_cmd", 64'(sram_csb), 64'(4'b1110));
        rst = 1'b1; wb_req = 1'b0;
        #1;
        chk("t1_csb_rst", 64'(sram_csb), 64'(4'hF));
        chk("t1_web_rst", 64'(sram_web), 64'(1));
        chk("t1_acks_rst", 64'({wb_ack_o, tx_ack_o, rx_ack_o}), 64'(0));
        chk("t1_addr_rst", 64'(sram_addr), 64'(0));
        chk("t1_wmask_rst", 64'(sram_wmask), 64'(0));
        chk("t1_din_rst", 64'(sram_din), 64'(0));
        chk("t1_rdata_rst", 64'({tx_rdata_o, wb_rdata_o}), 64'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        order.delete();
        idle(6);
        chk("t1_no_ack", 64'(order.size()), 64'(0));
        wb_xfer(1'b0, 12'h123, 4'hF, 32'h0, rd);
        chk("t1_not_written", 64'(rd), 64'(32'h5A5A0123));

        // WB byte-masked write to bank 3, then read back.
        wb_req = 1'b1; wb_we = 1'b1; wb_addr = 12'hC05; wb_sel = 4'b0011; wb_wdata = 32'hDEADBEEF;
        step();
        chk("t2_csb", 64'(sram_csb), 64'(4'b0111));
        chk("t2_addr", 64'(sram_addr), 64'(10'h005));
        chk("t2_wmask", 64'(sram_wmask), 64'(4'b0011));
        chk("t2_web", 64'(sram_web), 64'(0));
        step();
        chk("t2_csb_release", 64'(sram_csb), 64'(4'hF));
        step();
        chk("t2_ack", 64'(wb_ack_o), 64'(1));
        idle(1);
        wb_xfer(1'b0, 12'hC05, 4'hF, 32'h0, rd);
        chk("t2_readback", 64'(rd), 64'(32'h5A5ABEEF));

        // Word boundaries: bank 3 word 1023 and bank 0 word 0.
        wb_xfer(1'b1, 12'hFFF, 4'hF, 32'h0BADF00D, rd);
        wb_xfer(1'b1, 12'h000, 4'hF, 32'h600DCAFE, rd);
        wb_xfer(1'b0, 12'hFFF, 4'hF, 32'h0, rd);
        chk("t2_fff", 64'(rd), 64'(32'h0BADF00D));
        wb_xfer(1'b0, 12'h000, 4'hF, 32'h0, rd);
        chk("t2_000", 64'(rd), 64'(32'h600DCAFE));

        // Simultaneous requests after reset: RX, TX, WB.
        do_reset();
        order.delete();
        rx_req = 1'b1; rx_addr = 12'h801; rx_wdata = 32'h000000A1;
        tx_req = 1'b1; tx_addr = 12'h801;
        wb_req = 1'b1; wb_we = 1'b0; wb_addr = 12'h801; wb_sel = 4'hF;
        idle(12);
        chk("t3_count", 64'(order.size()), 64'(3));
        if (order.size() == 3) begin
            chk("t3_first", 64'(order[0]), 64'(0));
            chk("t3_second", 64'(order[1]), 64'(1));
            chk("t3_third", 64'(order[2]), 64'(2));
        end
        chk("t3_tx_sees_rx", 64'(last_tx_rd), 64'(32'h000000A1));

        // RX held continuously, WB joins: they alternate.
        do_reset();
        order.delete();
        rx_hold = 1'b1; rx_req = 1'b1; rx_addr = 12'h200; rx_wdata = 32'h0000B0B0;
        idle(2);
        wb_hold = 1'b1; wb_req = 1'b1; wb_we = 1'b1; wb_addr = 12'hE00; wb_sel = 4'hF; wb_wdata = 32'h0000CAFE;
        idle(26);
        rx_hold = 1'b0; wb_hold = 1'b0;
        idle(10);
        chk("t4_enough", 64'(order.size() >= 6), 64'(1));
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("t4_alternate", 64'(order[i]), 64'((i % 2 == 0) ? 0 : 2));

        // TX across the bank 0/1 boundary, then a held TX stream.
        csb_log.delete();
        tx_xfer(12'h3FF, rd);
        chk("t5_rd_3ff", 64'(rd), 64'(32'h5A5A03FF));
        tx_xfer(12'h400, rd);
        chk("t5_rd_400", 64'(rd), 64'(32'h5A5A0400));
        chk("t5_csb_count", 64'(csb_log.size()), 64'(2));
        if (csb_log.size() == 2) begin
            chk("t5_csb_bank0", 64'(csb_log[0]), 64'(4'b1110));
            chk("t5_csb_bank1", 64'(csb_log[1]), 64'(4'b1101));
        end
        tx_ack_cyc.delete();
        tx_hold = 1'b1; tx_req = 1'b1; tx_addr = 12'h7FF;
        idle(22);
        tx_hold = 1'b0;
        idle(6);
        chk("t5_stream_count", 64'(tx_ack_cyc.size() >= 5), 64'(1));
        for (int i = 1; i < 5 && i < tx_ack_cyc.size(); i++)
            chk("t5_stream_period", 64'(tx_ack_cyc[i] - tx_ack_cyc[i-1]), 64'(4));

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [11:0] ra;
            case ($urandom_range(0, 4))
                0: ra = 12'h000;
                1: ra = 12'h3FF;
                2: ra = 12'h400;
                3: ra = 12'hFFF;
                default: ra = 12'($urandom);
            endcase
            if (!rx_req && $urandom_range(0, 2) == 0) begin
                rx_req = 1'b1; rx_addr = ra; rx_wdata = $urandom;
            end else if (!tx_req && $urandom_range(0, 2) == 0) begin
                tx_req = 1'b1; tx_addr = ra;
            end else if (!wb_req && $urandom_range(0, 2) == 0) begin
                wb_req = 1'b1; wb_we = 1'($urandom); wb_addr = ra;
                wb_sel = 4'($urandom); wb_wdata = $urandom;
            end
            step();
        end
        idle(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
